latch_ctrl_seq: RTL

//  Clocked sequencer upstream of a DLatch bank: turns single-cycle commands into glitch-free,

---
 rtl/latch_ctrl_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/latch_ctrl_seq.sv
// Sequencer that turns single-cycle commands into timed D/ena/rst/pst waveforms for a DLatch bank.
// Optional LATCH_CTRL_READBACK_EN adds lat_q/rb_err readback checking in DONE.
module latch_ctrl_seq #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned OPEN_CYC  = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] lat_d,
    output logic             lat_ena,
    output logic             lat_rst,
    output logic             lat_pst,
    output logic             busy,
`ifdef LATCH_CTRL_READBACK_EN
    input  logic [WIDTH-1:0] lat_q,
    output logic             rb_err,
`endif
    output logic             done
);

    localparam int unsigned MAX_SO  = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
    localparam int unsigned MAX_CYC = (MAX_SO > HOLD_CYC) ? MAX_SO : HOLD_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_PRESET = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_OPEN  = 3'd2,
        S_HOLD  = 3'd3,
        S_PULSE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [1:0]         op_q, op_nxt;
    logic               accept;
    logic [WIDTH-1:0]   lat_d_nxt;
    logic               ena_nxt, rst_nxt, pst_nxt, done_nxt;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = cmd_valid && (state == S_IDLE);

    // State, counter and registered latch-pin outputs; reset holds the bank cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_q    <= OP_WRITE;
            lat_d   <= '0;
            lat_ena <= 1'b0;
            lat_rst <= 1'b1;
            lat_pst <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            op_q    <= op_nxt;
            lat_d   <= lat_d_nxt;
            lat_ena <= ena_nxt;
            lat_rst <= rst_nxt;
            lat_pst <= pst_nxt;
            done    <= done_nxt;
        end
    end

    // Next-state and window counter; each timed state is left when cnt reaches zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_nxt = cmd_op;
                    case (cmd_op)
                        OP_WRITE: begin
                            state_nxt = S_SETUP;
                            cnt_nxt   = CNT_W'(SETUP_CYC - 1);
                        end
                        OP_CLEAR, OP_PRESET: begin
                            state_nxt = S_PULSE;
                            cnt_nxt   = CNT_W'(OPEN_CYC - 1);
                        end
                        default: state_nxt = S_DONE;
                    endcase
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = S_OPEN;
                    cnt_nxt   = CNT_W'(OPEN_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_OPEN: begin
                if (cnt == '0) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_HOLD, S_PULSE: begin
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Next output values decoded from the next state so pins move in step with the FSM.
    always_comb begin
        lat_d_nxt = lat_d;
        ena_nxt   = 1'b0;
        rst_nxt   = 1'b0;
        pst_nxt   = 1'b0;
        done_nxt  = 1'b0;
        if (accept && (state_nxt == S_SETUP)) begin
            lat_d_nxt = cmd_data;
        end
        case (state_nxt)
            S_OPEN:  ena_nxt  = 1'b1;
            S_PULSE: begin
                rst_nxt = (op_nxt == OP_CLEAR);
                pst_nxt = (op_nxt == OP_PRESET);
            end
            S_DONE:  done_nxt = 1'b1;
            default: ;
        endcase
    end

`ifdef LATCH_CTRL_READBACK_EN
    logic [WIDTH-1:0] rb_exp;
    logic             rb_chk;

    // Expected bank contents for the command that just completed.
    always_comb begin
        rb_exp = lat_d;
        rb_chk = 1'b1;
        case (op_q)
            OP_WRITE:  rb_exp = lat_d;
            OP_CLEAR:  rb_exp = '0;
            OP_PRESET: rb_exp = '1;
            default:   rb_chk = 1'b0;
        endcase
    end

    // Sticky mismatch flag, captured on the edge leaving DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_err <= 1'b0;
        end else if (accept) begin
            rb_err <= 1'b0;
        end else if ((state == S_DONE) && rb_chk && (lat_q != rb_exp)) begin
            rb_err <= 1'b1;
        end
    end
`endif

endmodule
